// File: rtl/lsu_pkg.sv
// Shared types and helpers for the data-RAM load/store unit.
// Holds the FSM state encoding, RV32 load/store funct3 codes and the access-size lookup.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Bytes touched by an access; illegal codes report 4 but are flagged separately.
  function automatic logic [2:0] nbytes(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: nbytes = 3'd1;
      F3_H, F3_HU: nbytes = 3'd2;
      default:     nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data formatter: selects the low byte/half/word of a RAM word and
// sign- or zero-extends it according to the RV32 load funct3.
module load_extend
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] word_i,
  output logic [WIDTH-1:0] rdata_o
);

  always_comb begin
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = {{(WIDTH-8){word_i[7]}}, word_i[7:0]};
      F3_H:    rdata_o = {{(WIDTH-16){word_i[15]}}, word_i[15:0]};
      F3_W:    rdata_o = word_i;
      F3_BU:   rdata_o = {{(WIDTH-8){1'b0}}, word_i[7:0]};
      F3_HU:   rdata_o = {{(WIDTH-16){1'b0}}, word_i[15:0]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit driving a byte-addressed 32-bit RAM port with whole-word writes.
// Sub-word stores run a read-modify-write; range and funct3 errors are decided at accept.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 17
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // Request: a transfer happens on a rising edge where req_valid_i && req_ready_o.
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic [WIDTH-1:0] mem_a_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_wd_o,
  input  logic [WIDTH-1:0] mem_rd_i
);

  localparam logic [ADDR_W:0] MAX_ADDR = {1'b0, {ADDR_W{1'b1}}};

  lsu_state_e       r_state;
  logic             r_we_q;
  logic [2:0]       r_funct3_q;
  logic [WIDTH-1:0] r_addr_q;
  logic [WIDTH-1:0] r_wdata_q;
  logic             r_err_q;
  logic [WIDTH-9:0] r_word_hi_q;

  logic [ADDR_W:0]  w_last_byte;
  logic             w_hi_err;
  logic             w_range_err;
  logic             w_f3_err;
  logic             w_acc_err;
  logic [WIDTH-1:0] w_ext;

  // Address of the last byte touched, one bit wider so no wrap-around is possible.
  assign w_last_byte = {1'b0, req_addr_i[ADDR_W-1:0]}
                     + {{(ADDR_W-2){1'b0}}, nbytes(req_funct3_i)}
                     - {{ADDR_W{1'b0}}, 1'b1};
  assign w_hi_err    = (req_addr_i[WIDTH-1:ADDR_W] != '0);
  assign w_range_err = (w_last_byte > MAX_ADDR);
  assign w_f3_err    = req_we_i
                     ? !(req_funct3_i inside {F3_B, F3_H, F3_W})
                     : (req_funct3_i inside {3'b011, 3'b110, 3'b111});
  assign w_acc_err   = w_hi_err | w_range_err | w_f3_err;

  // Loads are formatted straight from the RAM read so the response registers in READ.
  load_extend #(.WIDTH(WIDTH)) u_load_extend (
    .funct3_i (r_funct3_q),
    .word_i   (mem_rd_i),
    .rdata_o  (w_ext)
  );

  assign req_ready_o = (r_state == S_IDLE);
  assign mem_a_o     = r_addr_q;
  assign mem_we_o    = rst_ni & (r_state == S_WRITE) & ~r_err_q;

  always_comb begin
    mem_wd_o = '0;
    if (r_state == S_WRITE) begin
      case (r_funct3_q)
        F3_B:    mem_wd_o = {r_word_hi_q, r_wdata_q[7:0]};
        F3_H:    mem_wd_o = {r_word_hi_q[WIDTH-9:8], r_wdata_q[15:0]};
        default: mem_wd_o = r_wdata_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_we_q      <= 1'b0;
      r_funct3_q  <= '0;
      r_addr_q    <= '0;
      r_wdata_q   <= '0;
      r_err_q     <= 1'b0;
      r_word_hi_q <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          rsp_valid_o <= 1'b0;
          if (req_valid_i) begin
            r_we_q     <= req_we_i;
            r_funct3_q <= req_funct3_i;
            r_addr_q   <= req_addr_i;
            r_wdata_q  <= req_wdata_i;
            r_err_q    <= w_acc_err;
            if (req_we_i && (req_funct3_i == F3_W) && !w_acc_err) r_state <= S_WRITE;
            else                                                  r_state <= S_READ;
          end
        end
        S_READ: begin
          r_word_hi_q <= mem_rd_i[WIDTH-1:8];
          // A legal store reaching READ is always SB/SH (SW bypasses it).
          if (r_we_q && !r_err_q) begin
            r_state <= S_WRITE;
          end else begin
            r_state     <= S_RESP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= (r_err_q || r_we_q) ? '0 : w_ext;
            rsp_err_o   <= r_err_q;
          end
        end
        S_WRITE: begin
          r_state     <= S_RESP;
          rsp_valid_o <= 1'b1;
          rsp_rdata_o <= '0;
          rsp_err_o   <= 1'b0;
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          rsp_valid_o <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu paired with a behavioural 128 KiB byte RAM.
// Table-driven request vectors plus hand sequences for back-to-back and mid-write reset.
module tb_data_mem_lsu;

  localparam int RAM_BYTES = 1 << 17;
  localparam logic [31:0] RAM_MASK = 32'(RAM_BYTES - 1);

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [7:0]  ram [0:RAM_BYTES-1];

  int checks   = 0;
  int failures = 0;

  data_mem_lsu #(.WIDTH(32), .ADDR_W(17)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .mem_a_o      (mem_a),
    .mem_we_o     (mem_we),
    .mem_wd_o     (mem_wd),
    .mem_rd_i     (mem_rd)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural RAM ----------------
  always_comb begin
    mem_rd = '0;
    for (int i = 0; i < 4; i++)
      mem_rd[8*i +: 8] = ram[(mem_a + 32'(i)) & RAM_MASK];
  end

  always @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        ram[(mem_a + 32'(i)) & RAM_MASK] <= mem_wd[8*i +: 8];
  end

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ram[(a + 32'(i)) & RAM_MASK];
    return w;
  endfunction

  task automatic ram_put(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ram[(a + 32'(i)) & RAM_MASK] = w[8*i +: 8];
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat, output int we_cnt,
                         output int we_k, output logic [31:0] wd);
    int wait_cyc;
    rdata = '0; err = 1'b0; lat = -1; we_cnt = 0; we_k = -1; wd = '0;
    wait_cyc = 0;
    @(negedge clk);
    while (!req_ready && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++;
        we_k = k;
        wd   = mem_wd;
      end
      if (rsp_valid) begin
        lat   = k;
        rdata = rsp_rdata;
        err   = rsp_err;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we_cnt;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[$];

  // ---------------- test ----------------
  initial begin
    logic [31:0] rdata, wd;
    logic        err;
    int          lat, we_cnt, we_k;
    int          bad;

    for (int i = 0; i < RAM_BYTES; i++) ram[i] = 8'h00;
    ram_put(32'h0001_0000, 32'h1234_5678);
    ram_put(32'h0001_0040, 32'hA1B2_C3D4);
    ram_put(32'h0001_0010, 32'hDEAD_BEEF);
    ram[17'h1FFFF] = 8'hA5;

    //          name          we  f3      addr          wdata         rdata         err   lat we  wd
    vecs.push_back('{"lw_basic",    0, 3'b010, 32'h0001_0000, 32'h0,        32'h1234_5678, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{"sb_hi",       1, 3'b000, 32'h0001_0003, 32'h0000_0080, 32'h0,        1'b0, 3, 1, 32'h0000_0080});
    vecs.push_back('{"sb_lo",       1, 3'b000, 32'h0001_0002, 32'h0000_007F, 32'h0,        1'b0, 3, 1, 32'h0000_807F});
    vecs.push_back('{"lb_neg",      0, 3'b000, 32'h0001_0003, 32'h0,        32'hFFFF_FF80, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{"lbu",         0, 3'b100, 32'h0001_0003, 32'h0,        32'h0000_0080, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{"lh_neg",      0, 3'b001, 32'h0001_0002, 32'h0,        32'hFFFF_807F, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{"lhu",         0, 3'b101, 32'h0001_0002, 32'h0,        32'h0000_807F, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{"lw_mix",      0, 3'b010, 32'h0001_0000, 32'h0,        32'h807F_5678, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{"sh",          1, 3'b001, 32'h0001_0000, 32'h1111_BEEF, 32'h0,        1'b0, 3, 1, 32'h807F_BEEF});
    vecs.push_back('{"lw_after_sh", 0, 3'b010, 32'h0001_0000, 32'h0,        32'h807F_BEEF, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{"lw_misal",    0, 3'b010, 32'h0001_0001, 32'h0,        32'h0080_7FBE, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{"sw_misal",    1, 3'b010, 32'h0001_0001, 32'h1122_3344, 32'h0,        1'b0, 2, 1, 32'h1122_3344});
    vecs.push_back('{"sb_rmw",      1, 3'b000, 32'h0001_0001, 32'hAABB_CCDD, 32'h0,        1'b0, 3, 1, 32'h1122_33DD});
    vecs.push_back('{"lw_rmw",      0, 3'b010, 32'h0001_0001, 32'h0,        32'h1122_33DD, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{"sw_oor",      1, 3'b010, 32'h0002_0000, 32'h1234_5678, 32'h0,        1'b1, 2, 0, 32'h0});
    vecs.push_back('{"lw_top",      0, 3'b010, 32'h0001_FFFE, 32'h0,        32'h0,        1'b1, 2, 0, 32'h0});
    vecs.push_back('{"lb_top",      0, 3'b000, 32'h0001_FFFF, 32'h0,        32'hFFFF_FFA5, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{"lh_top",      0, 3'b001, 32'h0001_FFFF, 32'h0,        32'h0,        1'b1, 2, 0, 32'h0});
    vecs.push_back('{"sw_top",      1, 3'b010, 32'h0001_FFFC, 32'h0102_0304, 32'h0,        1'b0, 2, 1, 32'h0102_0304});
    vecs.push_back('{"lbu_top",     0, 3'b100, 32'h0001_FFFF, 32'h0,        32'h0000_0001, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{"ld_f3_011",   0, 3'b011, 32'h0001_0000, 32'h0,        32'h0,        1'b1, 2, 0, 32'h0});
    vecs.push_back('{"ld_f3_110",   0, 3'b110, 32'h0001_0000, 32'h0,        32'h0,        1'b1, 2, 0, 32'h0});
    vecs.push_back('{"st_f3_100",   1, 3'b100, 32'h0001_0000, 32'h5555_5555, 32'h0,        1'b1, 2, 0, 32'h0});
    vecs.push_back('{"sh_hi_addr",  1, 3'b001, 32'h8001_0000, 32'h5555_5555, 32'h0,        1'b1, 2, 0, 32'h0});

    // ---- reset ----
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check32("rst_ready", 32'(req_ready), 32'd1);
    check32("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check32("rst_rdata", rsp_rdata, 32'h0);
    check32("rst_err", 32'(rsp_err), 32'd0);
    check32("rst_mem_we", 32'(mem_we), 32'd0);
    check32("rst_mem_a", mem_a, 32'h0);
    check32("rst_mem_wd", mem_wd, 32'h0);

    // ---- table ----
    foreach (vecs[i]) begin
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rdata, err, lat, we_cnt, we_k, wd);
      check_int({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
      check32({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
      check32({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
      check_int({vecs[i].name, "_we_pulses"}, we_cnt, vecs[i].exp_we_cnt);
      if (vecs[i].exp_we_cnt > 0) begin
        check_int({vecs[i].name, "_we_cycle"}, we_k, vecs[i].exp_lat - 1);
        check32({vecs[i].name, "_wd"}, wd, vecs[i].exp_wd);
      end
    end

    // ---- back-to-back LW then SW with valid held high ----
    @(negedge clk);
    check32("b2b_ready0", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0001_0040; req_wdata = '0;
    @(posedge clk);
    #1 begin
      req_we = 1'b1; req_addr = 32'h0001_0020; req_wdata = 32'hCAFE_F00D;
    end
    @(negedge clk);
    check32("b2b_k1_ready", 32'(req_ready), 32'd0);
    check32("b2b_k1_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check32("b2b_k2_rsp", 32'(rsp_valid), 32'd1);
    check32("b2b_k2_rdata", rsp_rdata, 32'hA1B2_C3D4);
    check32("b2b_k2_ready", 32'(req_ready), 32'd0);
    check32("b2b_k2_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    check32("b2b_k3_ready", 32'(req_ready), 32'd1);
    check32("b2b_k3_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check32("b2b_k4_we", 32'(mem_we), 32'd1);
    check32("b2b_k4_wd", mem_wd, 32'hCAFE_F00D);
    check32("b2b_k4_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check32("b2b_k5_rsp", 32'(rsp_valid), 32'd1);
    check32("b2b_k5_err", 32'(rsp_err), 32'd0);
    check32("b2b_k5_rdata", rsp_rdata, 32'h0);
    @(posedge clk);
    #1 check32("b2b_ram", ram_word(32'h0001_0020), 32'hCAFE_F00D);

    // ---- reset during the WRITE cycle of SW ----
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0001_0010; req_wdata = 32'h5555_5555;
    @(posedge clk);
    #1 begin
      req_valid = 1'b0;
      rst_n     = 1'b0;
    end
    @(negedge clk);
    check32("rstw_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check32("rstw_ready", 32'(req_ready), 32'd1);
    check32("rstw_rsp", 32'(rsp_valid), 32'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || mem_we) bad++;
    end
    check_int("rstw_quiet", bad, 0);
    check32("rstw_ram", ram_word(32'h0001_0010), 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
